// File: rtl/tbb_dispatch.sv
// Round-robin batch scheduler: streams LINES_PER_BATCH host lines into one granted task batch buffer.
// Optional perf counters (batch_cnt_o, stall_cnt_o) are built only when TBB_DISPATCH_PERF_EN is defined.
module tbb_dispatch #(
  parameter int NUM_PE          = 4,
  parameter int TBB_ADDR_WIDTH  = 4,
  parameter int TBB_DATA_WIDTH  = 512,
  parameter int LINES_PER_BATCH = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_PE-1:0]         tbb_request_i,
  input  logic [NUM_PE-1:0]         tbb_full_i,
  output logic                      rd_req_valid_o,
  input  logic                      rd_req_ready_i,
  input  logic                      rd_rsp_valid_i,
  input  logic [TBB_DATA_WIDTH-1:0] rd_rsp_data_i,
  output logic [NUM_PE-1:0]         tbb_wr_en_o,
  output logic [TBB_ADDR_WIDTH-1:0] tbb_wr_addr_o,
  output logic [TBB_DATA_WIDTH-1:0] tbb_wr_din_o,
  output logic                      busy_o,
  output logic                      rsp_err_o
`ifdef TBB_DISPATCH_PERF_EN
  ,
  output logic [31:0]               batch_cnt_o,
  output logic [31:0]               stall_cnt_o
`endif
);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CW = $clog2(LINES_PER_BATCH) + 1;

  typedef enum logic [1:0] {IDLE, GRANT, FILL, DONE} state_t;

  state_t                    state_q;
  logic [PW-1:0]             rr_q, gnt_q, sel_d, rr_d;
  logic [CW-1:0]             req_cnt_q, rsp_cnt_q;
  logic [NUM_PE-1:0]         elig, gnt_oh, wr_en_q;
  logic [TBB_ADDR_WIDTH-1:0] wr_addr_q;
  logic [TBB_DATA_WIDTH-1:0] wr_din_q;
  logic                      rsp_err_q, req_fire, rsp_acc;

  assign elig = tbb_request_i & ~tbb_full_i;

  // Scan downward so the smallest offset from rr_q wins.
  always_comb begin
    sel_d = rr_q;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (elig[(int'(rr_q) + k) % NUM_PE]) sel_d = PW'((int'(rr_q) + k) % NUM_PE);
    end
  end

  assign rr_d     = (gnt_q == PW'(NUM_PE - 1)) ? '0 : gnt_q + 1'b1;
  assign gnt_oh   = NUM_PE'(1) << gnt_q;
  assign rd_req_valid_o = (state_q == FILL) && (req_cnt_q < CW'(LINES_PER_BATCH));
  assign req_fire = rd_req_valid_o && rd_req_ready_i;
  // A response is only legal against an outstanding request of the current batch.
  assign rsp_acc  = rd_rsp_valid_i && (state_q == FILL) && (rsp_cnt_q != req_cnt_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_din_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wr_en_q <= '0;
      if (rd_rsp_valid_i && !rsp_acc) rsp_err_q <= 1'b1;
      case (state_q)
        IDLE: if (|elig) begin
          gnt_q   <= sel_d;
          state_q <= GRANT;
        end
        GRANT: begin
          req_cnt_q <= '0;
          rsp_cnt_q <= '0;
          state_q   <= FILL;
        end
        FILL: begin
          if (req_fire) req_cnt_q <= req_cnt_q + 1'b1;
          if (rsp_acc) begin
            wr_en_q   <= gnt_oh;
            wr_addr_q <= TBB_ADDR_WIDTH'(rsp_cnt_q);
            wr_din_q  <= rd_rsp_data_i;
            rsp_cnt_q <= rsp_cnt_q + 1'b1;
            if (rsp_cnt_q == CW'(LINES_PER_BATCH - 1)) state_q <= DONE;
          end
        end
        DONE: begin
          rr_q    <= rr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tbb_wr_en_o   = wr_en_q;
  assign tbb_wr_addr_o = wr_addr_q;
  assign tbb_wr_din_o  = wr_din_q;
  assign busy_o        = (state_q != IDLE);
  assign rsp_err_o     = rsp_err_q;

`ifdef TBB_DISPATCH_PERF_EN
  logic [31:0] batch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      batch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == DONE) batch_cnt_q <= batch_cnt_q + 1'b1;
      if (rd_req_valid_o && !rd_req_ready_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign batch_cnt_o = batch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
